// File: rtl/frame_block_reader_if.sv
// Signal bundle between a frame producer / AXI read observer and frame_block_reader.
// The reader sits on the slave modport; the frame source and bus model use master.
interface frame_block_reader_if #(
    parameter int ADDR_WIDTH = 32
) ();
    logic [15:0]           frame_height;
    logic [15:0]           frame_width;
    logic                  frame_ready;
    logic [ADDR_WIDTH-1:0] frame_addr;
    logic                  rvalid;
    logic                  rready;
    logic                  rlast;
    logic                  arready;
    logic                  start_read;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [31:0]           read_len;
    logic [2:0]            read_size;
    logic [1:0]            read_burst;
    logic [ADDR_WIDTH-1:0] base_addr_out;
    logic                  pixel_en;
    logic                  start_of_frame;
    logic                  end_of_block;
    logic                  frame_done;
    logic                  busy;
    logic                  overflow;
    logic                  protocol_err;

    modport slave (
        input  frame_height, frame_width, frame_ready, frame_addr,
        input  rvalid, rready, rlast, arready,
        output start_read, read_addr, read_len, read_size, read_burst,
        output base_addr_out, pixel_en, start_of_frame, end_of_block,
        output frame_done, busy, overflow, protocol_err
    );

    modport master (
        output frame_height, frame_width, frame_ready, frame_addr,
        output rvalid, rready, rlast, arready,
        input  start_read, read_addr, read_len, read_size, read_burst,
        input  base_addr_out, pixel_en, start_of_frame, end_of_block,
        input  frame_done, busy, overflow, protocol_err
    );
endinterface

// File: rtl/frame_block_reader.sv
// Walks a stored frame in BLOCK_SIZE x BLOCK_SIZE tiles, issuing one burst per tile row
// and tracking the observed read data; one frame can be queued while another is in flight.
module frame_block_reader #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BLOCK_SIZE = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    frame_block_reader_if.slave  bus
);
    localparam int BPP = DATA_WIDTH / 8;
    localparam int KW  = $clog2(BLOCK_SIZE);
    localparam int CW  = KW + 2;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_REQ       = 3'd1;
    localparam logic [2:0] S_WAIT_DATA = 3'd2;
    localparam logic [2:0] S_NEXT      = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [15:0]           w_q, w_d;
    logic [15:0]           nbw_q, nbw_d;
    logic [15:0]           nbh_q, nbh_d;
    logic [15:0]           bi_q, bi_d;
    logic [15:0]           bj_q, bj_d;
    logic [KW-1:0]         k_q, k_d;
    logic [CW-1:0]         beat_q, beat_d;
    logic                  first_q, first_d;
    logic [ADDR_WIDTH-1:0] read_addr_q, read_addr_d;
    logic                  overflow_q, overflow_d;
    logic                  perr_q, perr_d;

    logic                  pixel_en;
    logic                  pop, capture, fill;
    logic [CW-1:0]         beat_next;
    logic [ADDR_WIDTH-1:0] row, col, offset;

    assign pixel_en = bus.rvalid & bus.rready & (state_q == S_WAIT_DATA);

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the case infers a latch.
        state_d      = state_q;
        base_d       = base_q;
        pend_addr_d  = pend_addr_q;
        pend_valid_d = pend_valid_q;
        w_d          = w_q;
        nbw_d        = nbw_q;
        nbh_d        = nbh_q;
        bi_d         = bi_q;
        bj_d         = bj_q;
        k_d          = k_q;
        beat_d       = beat_q;
        first_d      = first_q;
        overflow_d   = overflow_q;
        perr_d       = perr_q;
        beat_next    = (beat_q == '1) ? beat_q : beat_q + CW'(1);

        // A queued frame is started from DONE, or from IDLE if it landed there during DONE.
        pop     = pend_valid_q && (state_q == S_DONE || state_q == S_IDLE);
        capture = (state_q == S_IDLE) && !pend_valid_q && bus.frame_ready;
        fill    = bus.frame_ready && !capture && (!pend_valid_q || pop);

        if (bus.frame_ready && !capture && pend_valid_q && !pop) overflow_d = 1'b1;
        if (fill) begin
            pend_valid_d = 1'b1;
            pend_addr_d  = bus.frame_addr;
        end else if (pop) begin
            pend_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (pop || capture) begin
                    base_d  = pop ? pend_addr_q : bus.frame_addr;
                    w_d     = bus.frame_width;
                    nbw_d   = bus.frame_width >> KW;
                    nbh_d   = bus.frame_height >> KW;
                    bi_d    = '0;
                    bj_d    = '0;
                    k_d     = '0;
                    first_d = 1'b1;
                    state_d = (nbw_d == '0 || nbh_d == '0) ? S_DONE : S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                beat_d  = '0;
                state_d = S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
                if (pixel_en) begin
                    beat_d = beat_next;
                    if (bus.rlast != (beat_next == CW'(BLOCK_SIZE))) perr_d = 1'b1;
                    if (bus.rlast) state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                state_d = S_REQ;
                if (k_q == KW'(BLOCK_SIZE - 1)) begin
                    k_d = '0;
                    if (bj_q == nbw_q - 16'd1) begin
                        bj_d = '0;
                        if (bi_q == nbh_q - 16'd1) state_d = S_DONE;
                        else                       bi_d = bi_q + 16'd1;
                    end else begin
                        bj_d = bj_q + 16'd1;
                    end
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pixel_en) first_d = 1'b0;

        // Descriptor is computed from the next counters and latched only on entry to REQ.
        row         = ADDR_WIDTH'(bi_d) * ADDR_WIDTH'(BLOCK_SIZE) + ADDR_WIDTH'(k_d);
        col         = ADDR_WIDTH'(bj_d) * ADDR_WIDTH'(BLOCK_SIZE);
        offset      = (row * ADDR_WIDTH'(w_d) + col) * ADDR_WIDTH'(BPP);
        read_addr_d = (state_d == S_REQ && state_q != S_REQ) ? base_d + offset : read_addr_q;
    end

    // NOTE: non-blocking updates so every register samples the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            pend_addr_q  <= '0;
            pend_valid_q <= 1'b0;
            w_q          <= '0;
            nbw_q        <= '0;
            nbh_q        <= '0;
            bi_q         <= '0;
            bj_q         <= '0;
            k_q          <= '0;
            beat_q       <= '0;
            first_q      <= 1'b0;
            read_addr_q  <= '0;
            overflow_q   <= 1'b0;
            perr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            pend_addr_q  <= pend_addr_d;
            pend_valid_q <= pend_valid_d;
            w_q          <= w_d;
            nbw_q        <= nbw_d;
            nbh_q        <= nbh_d;
            bi_q         <= bi_d;
            bj_q         <= bj_d;
            k_q          <= k_d;
            beat_q       <= beat_d;
            first_q      <= first_d;
            read_addr_q  <= read_addr_d;
            overflow_q   <= overflow_d;
            perr_q       <= perr_d;
        end
    end

    assign bus.pixel_en       = pixel_en;
    assign bus.start_of_frame = pixel_en & first_q;
    assign bus.start_read     = (state_q == S_REQ);
    assign bus.end_of_block   = (state_q == S_NEXT) && (k_q == KW'(BLOCK_SIZE - 1));
    assign bus.frame_done     = (state_q == S_DONE);
    assign bus.busy           = (state_q != S_IDLE);
    assign bus.overflow       = overflow_q;
    assign bus.protocol_err   = perr_q;
    assign bus.read_addr      = read_addr_q;
    assign bus.base_addr_out  = base_q;
    assign bus.read_len       = 32'(BLOCK_SIZE - 1);
    assign bus.read_size      = 3'($clog2(BPP));
    assign bus.read_burst     = 2'b01;
endmodule

// File: tb/tb_frame_block_reader.sv
// Randomized bench for frame_block_reader: a bus model answers each burst, a monitor logs
// descriptors and strobes, and a loop-based tile model supplies the expected address order.
module tb_frame_block_reader;
    localparam int BS  = 4;
    localparam int BPP = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    frame_block_reader_if #(.ADDR_WIDTH(32)) bus ();

    frame_block_reader #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BLOCK_SIZE(BS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- bus model ----------------
    int   burst_len  = 0;     // 0 = compliant BS-beat burst; otherwise rlast on that beat
    logic slave_kill = 1'b0;

    initial begin
        bus.rvalid = 1'b0;
        bus.rready = 1'b0;
        bus.rlast  = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus.start_read && !slave_kill) begin
                int  nb;
                logic acc;
                nb = (burst_len != 0) ? burst_len : BS;
                burst_len = 0;
                @(posedge clk); #1;
                for (int b = 1; b <= nb && !slave_kill; b++) begin
                    do begin
                        bus.rvalid = ($urandom_range(0, 3) != 0);
                        bus.rready = ($urandom_range(0, 3) != 0);
                        bus.rlast  = (b == nb);
                        acc = bus.rvalid && bus.rready;
                        @(posedge clk); #1;
                    end while (!acc && !slave_kill);
                end
                bus.rvalid = 1'b0;
                bus.rready = 1'b0;
                bus.rlast  = 1'b0;
            end
        end
    end

    // ---------------- monitor ----------------
    logic [31:0] addr_log [8192];
    int          n_bursts = 0, n_pix = 0, n_eob = 0, n_done = 0;
    int          sof_err = 0, desc_err = 0;
    logic        expect_first = 1'b1;
    logic [31:0] last_ra = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            expect_first = 1'b1;
            last_ra      = '0;
        end else begin
            if (bus.start_read) begin
                addr_log[n_bursts % 8192] = bus.read_addr;
                n_bursts++;
                last_ra = bus.read_addr;
                if (bus.read_len != BS - 1 || bus.read_size != 3'd2 || bus.read_burst != 2'b01)
                    desc_err++;
            end else if (bus.read_addr != last_ra) begin
                desc_err++;
            end
            if (bus.pixel_en) begin
                n_pix++;
                if (bus.start_of_frame != expect_first) sof_err++;
                expect_first = 1'b0;
            end else if (bus.start_of_frame) begin
                sof_err++;
            end
            if (bus.end_of_block) n_eob++;
            if (bus.frame_done) begin
                n_done++;
                expect_first = 1'b1;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] exp_q [$];

    task automatic model_add(input logic [31:0] base, input int w, input int h);
        for (int bi = 0; bi < h / BS; bi++)
            for (int bj = 0; bj < w / BS; bj++)
                for (int k = 0; k < BS; k++)
                    exp_q.push_back(base + 32'(((bi * BS + k) * w + bj * BS) * BPP));
    endtask

    task automatic compare_log(input int start);
        check("n_bursts", n_bursts - start, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (start + i < n_bursts)
                check($sformatf("read_addr[%0d]", i), addr_log[(start + i) % 8192], exp_q[i]);
        exp_q.delete();
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic pulse(input logic [31:0] addr, input int w, input int h);
        @(negedge clk);
        bus.frame_addr   = addr;
        bus.frame_width  = 16'(w);
        bus.frame_height = 16'(h);
        bus.frame_ready  = 1'b1;
        @(negedge clk);
        bus.frame_ready  = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.frame_done && t < 20000);
        if (!bus.frame_done) check("frame_done_timeout", 32'(bus.frame_done), 1);
    endtask

    task automatic run_frame(input logic [31:0] base, input int w, input int h,
                             input int pix_adj, input logic perr_exp);
        int s_b, s_p, s_e, s_d, nblk;
        s_b = n_bursts; s_p = n_pix; s_e = n_eob; s_d = n_done;
        pulse(base, w, h);
        wait_done();
        @(negedge clk);
        model_add(base, w, h);
        nblk = (w / BS) * (h / BS);
        compare_log(s_b);
        check("pixel_count", n_pix - s_p, nblk * BS * BS + pix_adj);
        check("end_of_block_count", n_eob - s_e, nblk);
        check("frame_done_count", n_done - s_d, 1);
        check("protocol_err", 32'(bus.protocol_err), 32'(perr_exp));
    endtask

    task automatic check_reset_values();
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_start_read", 32'(bus.start_read), 0);
        check("rst_pixel_en", 32'(bus.pixel_en), 0);
        check("rst_frame_done", 32'(bus.frame_done), 0);
        check("rst_end_of_block", 32'(bus.end_of_block), 0);
        check("rst_overflow", 32'(bus.overflow), 0);
        check("rst_protocol_err", 32'(bus.protocol_err), 0);
        check("rst_read_addr", bus.read_addr, 0);
        check("rst_base_addr_out", bus.base_addr_out, 0);
        check("rst_read_len", bus.read_len, BS - 1);
        check("rst_read_size", 32'(bus.read_size), 2);
        check("rst_read_burst", 32'(bus.read_burst), 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int s_b, s_d, t;
        rst_n            = 1'b0;
        bus.frame_ready  = 1'b0;
        bus.frame_addr   = '0;
        bus.frame_width  = '0;
        bus.frame_height = '0;
        bus.arready      = 1'b0;   // held low: the reader must not depend on it
        repeat (3) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        @(negedge clk);

        run_frame(32'h0, 8, 8, 0, 1'b0);
        run_frame(32'h0000_0400, 10, 9, 0, 1'b0);
        for (int i = 0; i < 4; i++)
            run_frame((i == 0) ? 32'hFFFF_FF80 : ($urandom & 32'hFFFF_FFFC),
                      $urandom_range(4, 32), $urandom_range(4, 32), 0, 1'b0);

        // Zero-block frame: DONE right after capture, no burst.
        s_b = n_bursts;
        pulse(32'h3000, 2, 8);
        check("zero_blk_frame_done", 32'(bus.frame_done), 1);
        repeat (3) @(negedge clk);
        check("zero_blk_busy", 32'(bus.busy), 0);
        check("zero_blk_no_start_read", n_bursts - s_b, 0);

        // Queue one frame, drop the next.
        s_b = n_bursts; s_d = n_done;
        pulse(32'h0, 8, 8);
        repeat (5) @(negedge clk);
        pulse(32'h1000, 8, 8);
        repeat (3) @(negedge clk);
        pulse(32'h2000, 8, 8);
        check("overflow_set", 32'(bus.overflow), 1);
        wait_done();
        @(negedge clk);
        check("queued_start_read", 32'(bus.start_read), 1);
        check("queued_read_addr", bus.read_addr, 32'h1000);
        check("queued_base_addr", bus.base_addr_out, 32'h1000);
        wait_done();
        repeat (5) @(negedge clk);
        model_add(32'h0, 8, 8);
        model_add(32'h1000, 8, 8);
        compare_log(s_b);
        check("queued_done_count", n_done - s_d, 2);
        check("queued_idle_after", 32'(bus.busy), 0);

        // Early rlast on beat 3 of the first burst.
        burst_len = 3;
        run_frame(32'h0, 8, 8, -1, 1'b1);

        // Reset in the middle of a frame.
        s_b = n_bursts;
        t = n_pix;
        pulse(32'h400, 8, 8);
        for (int c = 0; c < 2000 && n_pix < t + 5; c++) @(negedge clk);
        check("midburst_reached", 32'(n_pix >= t + 5), 1);
        rst_n      = 1'b0;
        slave_kill = 1'b1;
        #1;
        check_reset_values();
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        slave_kill = 1'b0;
        run_frame(32'h800, 8, 8, 0, 1'b0);

        // rlast missing on beat 4, arriving on beat 5.
        burst_len = 5;
        run_frame(32'h0, 8, 8, 1, 1'b1);

        check("start_of_frame_errors", sof_err, 0);
        check("descriptor_errors", desc_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/frame_block_reader.md
FRAME_BLOCK_READER -- requirements
Module: frame_block_reader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning AXI data width; one pixel per beat.
REQ-003 SHALL have parameter BLOCK_SIZE, default 4, meaning block edge in pixels; power of two, 2..64.
REQ-004 SHALL have derived constant BPP = DATA_WIDTH/8, meaning bytes per pixel.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; rising edge.
REQ-006 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have ports frame_height and frame_width, input, 16 each, meaning frame size in pixels, sampled at frame start.
REQ-008 SHALL have port frame_ready, input, 1, meaning one-cycle pulse: frame stored at frame_addr.
REQ-009 SHALL have port frame_addr, input, ADDR_WIDTH, meaning frame base byte address, sampled with frame_ready.
REQ-010 SHALL have ports rvalid, rready, rlast and arready, input, 1 each, meaning observed AXI read handshake signals.
REQ-011 SHALL have port start_read, output, 1, meaning one-cycle burst request to the burst master.
REQ-012 SHALL have ports read_addr (ADDR_WIDTH), read_len (32), read_size (3) and read_burst (2), all outputs, meaning the burst descriptor.
REQ-013 SHALL have port base_addr_out, output, ADDR_WIDTH, meaning base of the frame in progress.
REQ-014 SHALL have ports pixel_en, start_of_frame, end_of_block, frame_done and busy, output, 1 each, meaning status and strobe outputs.
REQ-015 SHALL have ports overflow and protocol_err, output, 1 each, meaning sticky error flags.

Function
REQ-016 SHALL use FSM states IDLE, REQ, WAIT_DATA, NEXT and DONE.
REQ-017 IDLE with frame_ready SHALL capture frame_addr, height and width, clear the block/row counters, and go to REQ next cycle.
REQ-018 REQ SHALL last one cycle with start_read=1, then go to WAIT_DATA.
REQ-019 The descriptor SHALL be read_len = BLOCK_SIZE-1, read_size = log2(BPP), read_burst = 2'b01, and SHALL be held stable from REQ until the next REQ.
REQ-020 read_addr SHALL be base + ((bi*BLOCK_SIZE + k)*W + bj*BLOCK_SIZE)*BPP, computed at full ADDR_WIDTH with wrap modulo 2^ADDR_WIDTH.
REQ-021 Traversal order SHALL be: k (row in block) innermost, then bj (block column), then bi (block row).
REQ-022 Partial edge blocks, from W or H not a multiple of BLOCK_SIZE, SHALL be skipped; the block counts are floor(W/BS) and floor(H/BS).
REQ-023 If floor(W/BS)=0 or floor(H/BS)=0, IDLE SHALL go straight to DONE with no start_read.
REQ-024 pixel_en SHALL equal rvalid & rready & (state==WAIT_DATA), combinationally.
REQ-025 The beat counter SHALL increment on each pixel_en.
REQ-026 start_of_frame SHALL be high with pixel_en on the first beat of a frame.
REQ-027 In WAIT_DATA, an accepted beat with rlast SHALL go to NEXT.
REQ-028 If rlast arrives at a beat count other than BLOCK_SIZE, or BLOCK_SIZE beats are accepted without rlast, protocol_err SHALL set (sticky) and the FSM SHALL advance on rlast only.
REQ-029 end_of_block SHALL pulse in NEXT when k = BLOCK_SIZE-1.
REQ-030 NEXT SHALL last one cycle, advance k/bj/bi, and go to REQ, or to DONE after the last row of the last block.
REQ-031 DONE SHALL last one cycle with frame_done=1, then go to REQ if the pending slot is valid (popping it and restarting the counters), else to IDLE.
REQ-032 There SHALL be a one-entry pending slot for frame_addr.
REQ-033 frame_ready outside IDLE with the slot empty SHALL fill the slot; with the slot full it SHALL set overflow (sticky) and drop the frame.
REQ-034 frame_ready coinciding with DONE SHALL be accepted into the slot.
REQ-035 Pending frames SHALL use frame_height and frame_width sampled at pop time.
REQ-036 busy SHALL be 1 in every state except IDLE.
REQ-037 base_addr_out SHALL update on capture or pop.
REQ-038 arready SHALL be monitored only; it SHALL NOT gate the FSM.

Reset
REQ-039 rst_n low SHALL asynchronously force IDLE, all counters to 0, the pending slot empty, and start_read, pixel_en, start_of_frame, end_of_block, frame_done, busy, overflow and protocol_err to 0.
REQ-040 On reset, read_addr and base_addr_out SHALL be 0, read_len SHALL be BLOCK_SIZE-1, read_size SHALL be log2(BPP), and read_burst SHALL be 2'b01.
REQ-041 Reset mid-burst SHALL abandon the frame; later beats SHALL be ignored (pixel_en=0 in IDLE).

Verification
REQ-042 8x8 frame, BS=4, base 0x0, 32-bit data, compliant slave -> 16 bursts; read_addr 0x00,0x20,0x40,0x60,0x10,0x30,0x50,0x70,0x80,...,0xF0; 64 pixel_en; 4 end_of_block; one frame_done; protocol_err=0.
REQ-043 10x9 frame, BS=4 -> 2x2 blocks only; 16 bursts; no address with column >= 8 or row >= 8.
REQ-044 frame_ready at 0x1000 during frame A, then again at 0x2000 -> first queued and processed immediately after frame_done of A; second dropped; overflow=1.
REQ-045 Slave asserts rlast on beat 3 with BS=4 -> protocol_err=1; next REQ issues the following row address.
REQ-046 rst_n low during WAIT_DATA, then released -> all outputs at reset values; next frame_ready restarts at block (0,0) with start_of_frame on the first beat.
REQ-047 frame_width=2, BS=4 -> frame_done one cycle after the capture cycle; start_read never asserted.
